// File: rtl/jt9346_host.sv
// Command sequencer for a 93C46 serial EEPROM in x16 mode: READ, WRITE, EWEN and EWDS,
// with sclk derived from clk by a half-period divider and write-ready polling with timeout.
module jt9346_host #(
    parameter int DIV  = 4,
    parameter int TOUT = 480000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        go,
    input  logic [1:0]  op,
    input  logic [5:0]  addr,
    input  logic [15:0] din,
    output logic [15:0] dout,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic        scs,
    output logic        sclk,
    output logic        sdi,
    input  logic        sdo
);

    localparam logic [1:0]  OP_READ  = 2'd0;
    localparam logic [1:0]  OP_WRITE = 2'd1;
    localparam logic [1:0]  OP_EWEN  = 2'd2;
    localparam logic [7:0]  DIV_M1   = 8'(DIV - 1);
    localparam logic [19:0] TOUT_M1  = 20'(TOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_CSS, S_SHIFT, S_RDIN, S_CSL, S_POLL, S_DONE
    } state_t;

    state_t      r_state, w_next;
    logic [7:0]  r_div;
    logic        r_sclk;
    logic [4:0]  r_bit;
    logic [24:0] r_sr;
    logic [15:0] r_rd;
    logic [15:0] r_dout;
    logic [19:0] r_tout;
    logic        r_err;
    logic [1:0]  r_op;

    logic        w_half;
    logic [4:0]  w_last_bit;
    logic [24:0] w_frame;

    assign w_half     = (r_div == DIV_M1);
    assign w_last_bit = (r_op == OP_WRITE) ? 5'd24 : 5'd8;

    // Start bit, opcode and address; WRITE appends data, others pad with zeros.
    always_comb begin
        w_frame = 25'd0;
        case (op)
            OP_READ:  w_frame = {1'b1, 2'b10, addr, 16'h0000};
            OP_WRITE: w_frame = {1'b1, 2'b01, addr, din};
            OP_EWEN:  w_frame = {1'b1, 2'b00, 6'b110000, 16'h0000};
            default:  w_frame = {1'b1, 2'b00, 6'b000000, 16'h0000};
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (go) w_next = S_CSS;
            S_CSS:   if (w_half) w_next = S_SHIFT;
            S_SHIFT: if (w_half && r_sclk && r_bit == w_last_bit)
                         w_next = (r_op == OP_READ) ? S_RDIN : S_CSL;
            S_RDIN:  if (w_half && r_sclk && r_bit == 5'd15) w_next = S_CSL;
            S_CSL:   if (w_half) w_next = (r_op == OP_WRITE) ? S_POLL : S_DONE;
            S_POLL:  if (sdo || r_tout == TOUT_M1) w_next = S_DONE;
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_div  <= '0;
            r_sclk <= 1'b0;
            r_bit  <= '0;
            r_sr   <= '0;
            r_rd   <= '0;
            r_dout <= '0;
            r_tout <= '0;
            r_err  <= 1'b0;
            r_op   <= '0;
        end else begin
            // Half-period counter restarts on every sclk edge and every state change.
            r_div <= (w_half || w_next != r_state) ? 8'd0 : r_div + 8'd1;
            case (r_state)
                S_IDLE: begin
                    if (go) begin
                        r_op   <= op;
                        r_sr   <= w_frame;
                        r_err  <= 1'b0;
                        r_bit  <= '0;
                        r_sclk <= 1'b0;
                        r_tout <= '0;
                    end
                end
                S_SHIFT, S_RDIN: begin
                    if (w_half) begin
                        r_sclk <= ~r_sclk;
                        if (r_sclk) begin
                            r_bit <= (w_next != r_state) ? 5'd0 : r_bit + 5'd1;
                            if (r_state == S_SHIFT) r_sr <= {r_sr[23:0], 1'b0};
                            else                    r_rd <= {r_rd[14:0], sdo};
                        end
                    end
                end
                S_CSL: begin
                    if (w_half && r_op == OP_READ) r_dout <= r_rd;
                end
                S_POLL: begin
                    if (!sdo) begin
                        r_tout <= r_tout + 20'd1;
                        if (r_tout == TOUT_M1) r_err <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign scs  = (r_state == S_CSS) || (r_state == S_SHIFT) ||
                  (r_state == S_RDIN) || (r_state == S_POLL);
    assign sclk = r_sclk;
    assign sdi  = (r_state == S_SHIFT) ? r_sr[24] : 1'b0;
    assign busy = (r_state != S_IDLE) && (r_state != S_DONE);
    assign done = (r_state == S_DONE);
    assign err  = r_err;
    assign dout = r_dout;

endmodule

// File: tb/tb_jt9346_host.sv
// Directed bench for jt9346_host with a cycle-level 93C46 model on the serial pins.
module tb_jt9346_host;

    localparam logic [1:0] OP_READ  = 2'd0;
    localparam logic [1:0] OP_WRITE = 2'd1;
    localparam logic [1:0] OP_EWEN  = 2'd2;
    localparam logic [1:0] OP_EWDS  = 2'd3;

    logic        clk = 1'b0;
    logic        rst, go, sdo;
    logic [1:0]  op;
    logic [5:0]  addr;
    logic [15:0] din, dout;
    logic        busy, done, err, scs, sclk, sdi;

    jt9346_host #(.DIV(4), .TOUT(1000)) dut (
        .clk(clk), .rst(rst), .go(go), .op(op), .addr(addr), .din(din),
        .dout(dout), .busy(busy), .done(done), .err(err),
        .scs(scs), .sclk(sclk), .sdi(sdi), .sdo(sdo)
    );

    always #5 clk = ~clk;

    // Device model: counts sclk rises, records sdi, serves READ data.
    logic [15:0] mdl_mem;
    logic        poll_sdo;
    logic        rd_sdo = 1'b0;
    logic        prev_sclk = 1'b0;
    logic        is_rd = 1'b0;
    logic [24:0] cap = '0;
    int          rise_cnt = 0;

    assign sdo = rd_sdo | poll_sdo;

    always @(negedge clk) begin
        if (!busy) begin
            rise_cnt = 0;
            is_rd    = 1'b0;
            rd_sdo   = 1'b0;
        end else if (sclk && !prev_sclk) begin
            rise_cnt = rise_cnt + 1;
            cap      = {cap[23:0], sdi};
            if (rise_cnt == 3 && cap[2:0] == 3'b110) is_rd = 1'b1;
            if (is_rd && rise_cnt >= 10 && rise_cnt <= 25) rd_sdo = mdl_mem[25 - rise_cnt];
            else rd_sdo = 1'b0;
        end
        prev_sclk = sclk;
    end

    int n_chk = 0;
    int n_bad = 0;
    int cyc = 0;
    int t0 = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic start(input logic [1:0] o, input logic [5:0] a, input logic [15:0] d);
        go = 1'b1; op = o; addr = a; din = d;
        tick();
        go = 1'b0;
        t0 = cyc;
    endtask

    task automatic wait_done(input int budget);
        int n = 0;
        while (!done && n < budget) begin
            tick();
            n++;
        end
        chk("done_seen", {31'd0, done}, 32'd1);
    endtask

    task automatic after_done(input string tag);
        tick();
        chk({tag, "_done_low"}, {31'd0, done}, 32'd0);
        chk({tag, "_idle"}, {31'd0, busy}, 32'd0);
    endtask

    logic [24:0] exp_cap;
    int          pulses;

    initial begin
        rst = 1'b1; go = 1'b1; op = OP_EWEN; addr = '0; din = '0;
        poll_sdo = 1'b0; mdl_mem = 16'hA55A;
        repeat (3) tick();
        go = 1'b0; rst = 1'b0;
        tick();
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_pins", {29'd0, scs, sclk, sdi}, 32'd0);
        chk("rst_done_err", {30'd0, done, err}, 32'd0);
        chk("rst_dout", {16'd0, dout}, 32'd0);

        // READ 0x05 -> 0xA55A
        start(OP_READ, 6'h05, 16'h0);
        chk("css_pins", {29'd0, busy, scs, sclk}, 32'b110);
        wait_done(400);
        chk("rd_lat", cyc - t0, 32'd208);
        exp_cap = {1'b1, 2'b10, 6'h05, 16'h0};
        chk("rd_bits", {7'd0, cap}, {7'd0, exp_cap});
        chk("rd_rises", rise_cnt, 32'd25);
        chk("rd_dout", {16'd0, dout}, 32'h0000A55A);
        chk("rd_err", {31'd0, err}, 32'd0);
        chk("rd_done_pins", {28'd0, busy, scs, sclk, sdi}, 32'd0);
        after_done("rd");

        // WRITE 0x3F/0x1234, device ready 100 cycles into CSL
        start(OP_WRITE, 6'h3F, 16'h1234);
        while (cyc - t0 < 304) tick();
        chk("wr_not_early", {31'd0, done}, 32'd0);
        chk("wr_poll_scs", {30'd0, scs, sclk}, 32'b10);
        exp_cap = {1'b1, 2'b01, 6'h3F, 16'h1234};
        chk("wr_bits", {7'd0, cap}, {7'd0, exp_cap});
        chk("wr_rises", rise_cnt, 32'd25);
        poll_sdo = 1'b1;
        wait_done(10);
        poll_sdo = 1'b0;
        chk("wr_lat", cyc - t0, 32'd305);
        chk("wr_err", {31'd0, err}, 32'd0);
        chk("wr_dout_kept", {16'd0, dout}, 32'h0000A55A);
        after_done("wr");

        // WRITE with device never ready -> timeout
        start(OP_WRITE, 6'h01, 16'hBEEF);
        wait_done(2000);
        chk("to_lat", cyc - t0, 32'd1208);
        chk("to_err", {31'd0, err}, 32'd1);
        chk("to_scs", {31'd0, scs}, 32'd0);
        repeat (5) tick();
        chk("to_err_held", {31'd0, err}, 32'd1);

        // EWEN, also clears err on acceptance
        start(OP_EWEN, 6'h00, 16'h0);
        chk("ewen_err_clr", {31'd0, err}, 32'd0);
        wait_done(200);
        chk("ewen_lat", cyc - t0, 32'd80);
        chk("ewen_bits", {23'd0, cap[8:0]}, {23'd0, 9'b100110000});
        chk("ewen_rises", rise_cnt, 32'd9);
        chk("ewen_dout_kept", {16'd0, dout}, 32'h0000A55A);
        after_done("ewen");

        // EWDS
        start(OP_EWDS, 6'h2A, 16'h0);
        wait_done(200);
        chk("ewds_lat", cyc - t0, 32'd80);
        chk("ewds_bits", {23'd0, cap[8:0]}, {23'd0, 9'b100000000});
        after_done("ewds");

        // Reset at bit 12 of a WRITE
        start(OP_WRITE, 6'h2A, 16'hFFFF);
        while (rise_cnt < 12 && cyc - t0 < 400) tick();
        chk("mid_bit12", rise_cnt, 32'd12);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("mid_rst_pins", {28'd0, busy, scs, sclk, sdi}, 32'd0);
        chk("mid_rst_dout", {16'd0, dout}, 32'd0);
        tick();
        mdl_mem = 16'h0F0F;
        start(OP_READ, 6'h11, 16'h0);
        wait_done(400);
        chk("post_rst_lat", cyc - t0, 32'd208);
        exp_cap = {1'b1, 2'b10, 6'h11, 16'h0};
        chk("post_rst_bits", {7'd0, cap}, {7'd0, exp_cap});
        chk("post_rst_dout", {16'd0, dout}, 32'h00000F0F);
        after_done("post_rst");

        // go pulsed during an active READ must be ignored
        mdl_mem = 16'h1357;
        start(OP_READ, 6'h07, 16'h0);
        repeat (50) tick();
        go = 1'b1; op = OP_EWEN; addr = 6'h00;
        tick();
        go = 1'b0;
        wait_done(400);
        chk("ign_lat", cyc - t0, 32'd208);
        exp_cap = {1'b1, 2'b10, 6'h07, 16'h0};
        chk("ign_bits", {7'd0, cap}, {7'd0, exp_cap});
        chk("ign_dout", {16'd0, dout}, 32'h00001357);
        pulses = 0;
        for (int i = 0; i < 300; i++) begin
            tick();
            if (done) pulses++;
        end
        chk("ign_one_done", pulses, 32'd0);
        chk("ign_idle", {31'd0, busy}, 32'd0);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
